// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//   Single-clock synchronous FIFO with an occupancy count, programmable
//   almost_full/almost_empty thresholds, one-cycle overflow/underflow error
//   pulses, and an optional first-word-fall-through read mode.
//
// Parameters
//   WORD_SIZE  data width in bits
//   ADDR_SIZE  pointer width, DEPTH = 2**ADDR_SIZE
//   AF_THRESH  almost_full  when count >= AF_THRESH
//   AE_THRESH  almost_empty when count <= AE_THRESH
//   FWFT       0 = registered read (1-cycle latency), 1 = first-word-fall-through
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high; wins over wr_enb/rd_enb
//   data_in       write data
//   wr_enb        write request (accepted when not full)
//   rd_enb        read request (accepted when not empty)
//   data_out      read data
//   empty/full    count == 0 / count == DEPTH
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         occupancy, 0..DEPTH
//   overflow      pulse: a write was rejected on the previous edge
//   underflow     pulse: a read was rejected on the previous edge
// ---------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_SIZE = 4,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 wr_enb,
    input  logic                 rd_enb,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int DEPTH = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE + 1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] AF_C    = (ADDR_SIZE + 1)'(AF_THRESH);
    localparam logic [ADDR_SIZE:0] AE_C    = (ADDR_SIZE + 1)'(AE_THRESH);

    logic [WORD_SIZE-1:0] mem [DEPTH];

    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_SIZE:0]   count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;

    logic wr_accept;
    logic rd_accept;

    // Flags come from the registered count only, so they settle just after
    // the clock edge and never depend on this cycle's requests.
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Full blocks the write and empty blocks the read, which automatically
    // gives the read-wins-when-full / write-wins-when-empty behaviour for
    // simultaneous requests.
    assign wr_accept = wr_enb && !full;
    assign rd_accept = rd_enb && !empty;

    // Next-state for pointers, occupancy and error pulses.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = wr_enb && full;
        underflow_d = rd_enb && empty;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + ADDR_SIZE'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + ADDR_SIZE'(1);
        end

        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + (ADDR_SIZE + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_SIZE + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset returns the FIFO to empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array: not cleared by reset, but no write lands during reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_accept) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    generate
        if (FWFT == 0) begin : g_registered_read
            logic [WORD_SIZE-1:0] data_out_q, data_out_d;

            // Output register loads the head word on an accepted read and
            // otherwise holds the last word read.
            always_comb begin
                data_out_d = data_out_q;
                if (rd_accept) begin
                    data_out_d = mem[rd_ptr_q];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    data_out_q <= '0;
                end else begin
                    data_out_q <= data_out_d;
                end
            end

            assign data_out = data_out_q;
        end else begin : g_fwft_read
            // Head word is shown directly; forced to zero when nothing is stored
            // so stale array contents never leak out after reset or drain.
            assign data_out = empty ? '0 : mem[rd_ptr_q];
        end
    endgenerate

endmodule
